// File: rtl/bb_ram_pkg.sv
// rtl/bb_ram_pkg.sv - shared constants and types for the two-port RAM arbiter
package bb_ram_pkg;

  // Number of requesters sharing the RAM.
  localparam int N_REQ = 2;

  // Index of a requester (0 = CPU side, 1 = DMA side).
  typedef logic req_idx_t;

  // Command type carried on req_write.
  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin grant
module rr_arbiter2
  import bb_ram_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  req_idx_t         i_last_grant,
  output logic [N_REQ-1:0] o_grant,
  output req_idx_t         o_grant_idx
);

  // A lone requester always wins; under contention the one not served last wins.
  // With nobody requesting, the index parks on 0 so the RAM sees requester 0's address.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = 1'b0;
    case (i_req)
      2'b01: begin
        o_grant     = 2'b01;
        o_grant_idx = 1'b0;
      end
      2'b10: begin
        o_grant     = 2'b10;
        o_grant_idx = 1'b1;
      end
      2'b11: begin
        if (i_last_grant == 1'b1) begin
          o_grant     = 2'b01;
          o_grant_idx = 1'b0;
        end else begin
          o_grant     = 2'b10;
          o_grant_idx = 1'b1;
        end
      end
      default: begin
        o_grant     = '0;
        o_grant_idx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin sharing of one single-port RAM between two requesters
module ram_arbiter
  import bb_ram_pkg::*;
#(
  parameter int ADDRESS_BITS = 6,
  parameter int DATA_BITS    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [2*ADDRESS_BITS-1:0]   req_addr,
  input  logic [2*DATA_BITS-1:0]      req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_BITS-1:0]        rsp_rdata,
  output logic                        ram_enable,
  output logic [ADDRESS_BITS-1:0]     ram_address,
  output logic [DATA_BITS-1:0]        ram_data_in,
  input  logic [DATA_BITS-1:0]        ram_data_out
);

  logic [N_REQ-1:0] w_grant;
  req_idx_t         w_grant_idx;
  logic             w_accept;

  req_idx_t         r_last_grant;
  logic             r_pend_valid;
  req_idx_t         r_pend_id;

  rr_arbiter2 u_rr_arbiter2 (
    .i_req        (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

  // Grants are suppressed while reset is held so nothing is accepted or written.
  always_comb begin
    req_ready = reset ? '0 : w_grant;
    w_accept  = |(req_valid & req_ready);
  end

  // Steer the winner's command onto the RAM pins; only an accepted write strobes the RAM.
  always_comb begin
    ram_address = w_grant_idx ? req_addr[2*ADDRESS_BITS-1:ADDRESS_BITS]
                              : req_addr[ADDRESS_BITS-1:0];
    ram_data_in = w_grant_idx ? req_wdata[2*DATA_BITS-1:DATA_BITS]
                              : req_wdata[DATA_BITS-1:0];
    ram_enable  = w_accept && (req_write[w_grant_idx] == CMD_WRITE);
  end

  // Round-robin pointer and one-deep response pipeline; last_grant resets to 1 so
  // requester 0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_pend_valid <= 1'b0;
      r_pend_id    <= 1'b0;
    end else begin
      r_pend_valid <= w_accept;
      if (w_accept) begin
        r_last_grant <= w_grant_idx;
        r_pend_id    <= w_grant_idx;
      end
    end
  end

  // The response strobe follows the recorded issuer; data comes straight off the RAM register.
  always_comb begin
    rsp_valid = '0;
    if (r_pend_valid) begin
      rsp_valid[r_pend_id] = 1'b1;
    end
    rsp_rdata = ram_data_out;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a behavioural reference
module tb_ram_arbiter;

  localparam int AB = 6;
  localparam int DB = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid;
  logic [1:0]      req_write;
  logic [2*AB-1:0] req_addr;
  logic [2*DB-1:0] req_wdata;
  logic [1:0]      req_ready;
  logic [1:0]      rsp_valid;
  logic [DB-1:0]   rsp_rdata;
  logic            ram_enable;
  logic [AB-1:0]   ram_address;
  logic [DB-1:0]   ram_data_in;
  logic [DB-1:0]   ram_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  ram_arbiter #(.ADDRESS_BITS(AB), .DATA_BITS(DB)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .ram_enable   (ram_enable),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  // Attached single-port RAM: registered read, read-before-write.
  logic [DB-1:0] ram_mem [64];
  always @(posedge clk) begin
    ram_data_out <= ram_mem[ram_address];
    if (ram_enable) ram_mem[ram_address] <= ram_data_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, who was served last, and the queue of owed responses.
  logic [DB-1:0] m_mem [64];
  int            m_last;
  int            rsp_q_id[$];
  logic [DB-1:0] rsp_q_data[$];
  int            m_wait [2];

  always @(negedge clk) begin
    int            win;
    int            nv;
    logic [1:0]    exp_ready;
    logic [AB-1:0] a [2];
    logic [DB-1:0] d [2];
    a[0] = req_addr[AB-1:0];
    a[1] = req_addr[2*AB-1:AB];
    d[0] = req_wdata[DB-1:0];
    d[1] = req_wdata[2*DB-1:DB];
    if (reset) begin
      chk("rst_ready", {30'd0, req_ready}, 32'd0);
      chk("rst_ram_enable", {31'd0, ram_enable}, 32'd0);
      chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
      m_last = 1;
      rsp_q_id.delete();
      rsp_q_data.delete();
      m_wait[0] = 0;
      m_wait[1] = 0;
    end else begin
      // Response owed from the previous cycle's acceptance, if any.
      if (rsp_q_id.size() > 0) begin
        chk("m_rsp_valid", {30'd0, rsp_valid}, 32'd1 << rsp_q_id[0]);
        chk("m_rsp_rdata", {24'd0, rsp_rdata}, {24'd0, rsp_q_data[0]});
        void'(rsp_q_id.pop_front());
        void'(rsp_q_data.pop_front());
      end else begin
        chk("m_rsp_idle", {30'd0, rsp_valid}, 32'd0);
      end
      // Winner: the only valid requester, or the one not served last.
      nv = int'(req_valid[0]) + int'(req_valid[1]);
      if (nv == 0)      win = -1;
      else if (nv == 1) win = req_valid[0] ? 0 : 1;
      else              win = 1 - m_last;
      exp_ready = (win < 0) ? 2'b00 : (2'b01 << win);
      chk("m_ready", {30'd0, req_ready}, {30'd0, exp_ready});
      chk("m_ram_address", {26'd0, ram_address}, {26'd0, (win < 0) ? a[0] : a[win]});
      chk("m_ram_enable", {31'd0, ram_enable},
          (win >= 0 && req_write[win]) ? 32'd1 : 32'd0);
      if (win >= 0) begin
        chk("m_ram_data_in", {24'd0, ram_data_in}, {24'd0, d[win]});
        rsp_q_id.push_back(win);
        rsp_q_data.push_back(m_mem[a[win]]);
        if (req_write[win]) m_mem[a[win]] = d[win];
        m_last = win;
      end
      // A requester left waiting must be served on the following cycle.
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && win != i) begin
          m_wait[i]++;
          chk("starve", m_wait[i], (m_wait[i] < 2) ? m_wait[i] : 1);
        end else begin
          m_wait[i] = 0;
        end
      end
    end
  end

  task automatic cyc(input logic rst, input logic [1:0] v, input logic [1:0] w,
                     input logic [AB-1:0] a0, input logic [AB-1:0] a1,
                     input logic [DB-1:0] d0, input logic [DB-1:0] d1);
    @(posedge clk);
    #1;
    reset     = rst;
    req_valid = v;
    req_write = w;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]    v, w;
    logic [AB-1:0] a [2];
    logic [DB-1:0] d [2];
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = 8'(i * 37 + 11);
      m_mem[i]   = 8'(i * 37 + 11);
    end
    m_last = 1;
    m_wait[0] = 0;
    m_wait[1] = 0;
    reset = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", {30'd0, req_ready}, 32'd0);
    chk("reset_rsp", {30'd0, rsp_valid}, 32'd0);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0);

    // Write A5 to 0x05 from requester 0.
    cyc(0, 2'b01, 2'b01, 6'h05, 0, 8'hA5, 0);
    chk("t1_ready", {30'd0, req_ready}, 32'h1);
    chk("t1_enable", {31'd0, ram_enable}, 32'h1);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("t1_rsp", {30'd0, rsp_valid}, 32'h1);

    // Write 5A via requester 1, read back via requester 0 next cycle.
    cyc(0, 2'b10, 2'b10, 0, 6'h05, 0, 8'h5A);
    cyc(0, 2'b01, 2'b00, 6'h05, 0, 0, 0);
    chk("t2_wr_rsp", {30'd0, rsp_valid}, 32'h2);
    chk("t2_wr_old", {24'd0, rsp_rdata}, 32'hA5);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("t2_rd_rsp", {30'd0, rsp_valid}, 32'h1);
    chk("t2_rd_data", {24'd0, rsp_rdata}, 32'h5A);

    // Requester 1 goes once so the contention run starts with requester 0.
    cyc(0, 2'b10, 2'b00, 0, 6'h01, 0, 0);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 2'b11, 2'b00, 6'h02, 6'h03, 0, 0);
      chk("t3_grant", {30'd0, req_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("t3_rsp", {30'd0, rsp_valid}, (k % 2 == 0) ? 32'h2 : 32'h1);
    end

    // Requester 1 alone for three cycles, then contention hands it to requester 0.
    for (int k = 0; k < 3; k++) begin
      cyc(0, 2'b10, 2'b00, 0, 6'h07, 0, 0);
      chk("t4_alone", {30'd0, req_ready}, 32'h2);
    end
    cyc(0, 2'b11, 2'b00, 6'h08, 6'h07, 0, 0);
    chk("t4_switch", {30'd0, req_ready}, 32'h1);
    cyc(0, 2'b11, 2'b00, 6'h08, 6'h07, 0, 0);
    chk("t4_back", {30'd0, req_ready}, 32'h2);

    // Read accepted, then reset pulsed: response dropped, pointer and RAM contents survive.
    cyc(0, 2'b01, 2'b00, 6'h05, 0, 0, 0);
    cyc(1, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("t5_rsp_dropped", {30'd0, rsp_valid}, 32'h0);
    cyc(0, 2'b11, 2'b00, 6'h05, 6'h05, 0, 0);
    chk("t5_first", {30'd0, req_ready}, 32'h1);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("t5_rsp", {30'd0, rsp_valid}, 32'h1);
    chk("t5_data", {24'd0, rsp_rdata}, 32'h5A);

    // Wrap boundary: top and bottom addresses hold distinct data.
    cyc(0, 2'b01, 2'b01, 6'h3F, 0, 8'hC3, 0);
    cyc(0, 2'b10, 2'b10, 0, 6'h00, 0, 8'h3C);
    cyc(0, 2'b01, 2'b00, 6'h3F, 0, 0, 0);
    cyc(0, 2'b10, 2'b00, 0, 6'h00, 0, 0);
    chk("t6_3f", {24'd0, rsp_rdata}, 32'hC3);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("t6_00", {24'd0, rsp_rdata}, 32'h3C);

    // Randomized traffic; an unserved command is held stable or withdrawn.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!reset && req_valid[i] && !req_ready[i] && ($urandom % 4 != 0)) begin
          v[i] = 1'b1;
          w[i] = req_write[i];
          a[i] = (i == 0) ? req_addr[AB-1:0] : req_addr[2*AB-1:AB];
          d[i] = (i == 0) ? req_wdata[DB-1:0] : req_wdata[2*DB-1:DB];
        end else begin
          v[i] = ($urandom % 3 != 0);
          w[i] = $urandom % 2;
          a[i] = ($urandom % 2) ? AB'($urandom % 4) : AB'($urandom);
          d[i] = DB'($urandom);
        end
      end
      cyc(($urandom % 150) == 0, v, w, a[0], a[1], d[0], d[1]);
    end

    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter that shares one single-port `ram` instance (1-cycle registered read, write-enable, read-before-write) between two independent requesters. Each requester issues read or write commands with a valid/ready handshake. Each accepted command gets a fixed-latency response one cycle later. The block sits between the CPU-side and DMA-side masters and the `ram` instance, and owns the `ram` address, data and enable pins.

## Interface
Parameters:
- ADDRESS_BITS, 6, RAM address width; must match the attached `ram`
- DATA_BITS, 8, RAM data width; must match the attached `ram`

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock, shared with `ram`
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester command valid; bit i = requester i
- req_write  in  2  per-requester command type: 1 = write, 0 = read
- req_addr  in  2*ADDRESS_BITS  packed addresses; requester i at [i*ADDRESS_BITS +: ADDRESS_BITS]
- req_wdata  in  2*DATA_BITS  packed write data; requester i at [i*DATA_BITS +: DATA_BITS]
- req_ready  out  2  one-hot-or-zero grant; command i is accepted when req_valid[i] & req_ready[i]
- rsp_valid  out  2  one-hot-or-zero response strobe, one cycle per accepted command
- rsp_rdata  out  DATA_BITS  RAM read data for the responding requester
- ram_enable  out  1  to `ram` enable (write strobe)
- ram_address  out  ADDRESS_BITS  to `ram` address
- ram_data_in  out  DATA_BITS  to `ram` data_in
- ram_data_out  in  DATA_BITS  from `ram` data_out

## Operation
- Grant logic is combinational from req_valid and the registered pointer `last_grant` (1 bit).
  - Only one requester valid: it is granted.
  - Both valid: grant the requester != last_grant.
  - None valid: req_ready = 2'b00.
- On each accepted command, `last_grant` takes the granted index. With no acceptance it holds.
- RAM drive:
  - ram_address = winner's req_addr; when no grant, requester 0's req_addr.
  - ram_data_in = winner's req_wdata.
  - ram_enable = grant & winner's req_write; otherwise 0.
- Response pipeline: registered `pend_valid` (1 bit) and `pend_id` (1 bit) record each accepted command.
  - Next cycle: rsp_valid[pend_id] = pend_valid.
  - rsp_rdata = ram_data_out, unregistered from the `ram` output register.
- Writes also produce a response. Its rsp_rdata is the pre-write contents (the `ram` is read-before-write). Requesters may ignore it.
- Response ordering is strict issue order. There is no response backpressure; requesters must always sink rsp_valid.
- Requester command fields must stay stable while req_valid=1 and req_ready=0. Dropping req_valid before acceptance is legal; the command is withdrawn.

## Timing
- Reset values: last_grant=1 (so requester 0 wins the first contention), pend_valid=0, pend_id=0.
  - Therefore rsp_valid=2'b00 in reset.
  - req_ready and ram_enable are 0 while reset is asserted, gated by reset.
- Latency: accept in cycle N -> rsp_valid in cycle N+1. Throughput is one command per cycle, back-to-back, alternating between requesters under contention.
- Starvation bound: a continuously valid requester is granted within 2 cycles.
- Same-address sequences:
  - Write in N then read in N+1: the read returns the new data in N+2.
  - Read and write never coincide; they are serialized by the grant.
- Reset asserted mid-operation: the pending response is discarded (rsp_valid forced 0 asynchronously) and no RAM write occurs while reset is high. RAM contents are not cleared.
- Address wrap: addresses are used modulo 2**ADDRESS_BITS; no range checking.

## Structure
- Shared package `bb_ram_pkg`:
  - localparam N_REQ = 2.
  - Requester index typedef (1 bit).
  - Command-type constants CMD_READ=0 and CMD_WRITE=1.
- One natural sub-module, `rr_arbiter2`: the combinational two-way round-robin grant from (req, last_grant). The top instantiates it and owns the pointer and response registers.
- `ram_arbiter` does not instantiate `ram`. The integrating level connects the ram_* pins.

## Test plan
- Reset, then write from requester 0 (req_write=1, addr 0x05, wdata 0xA5) -> req_ready=2'b01 in the same cycle, ram_enable=1, rsp_valid=2'b01 next cycle.
- Write 0x5A to addr 0x05 via requester 1, then read 0x05 via requester 0 in the next cycle -> requester 0's rsp_rdata=0x5A two cycles after the write.
- Both requesters hold req_valid=1 for 6 cycles, all reads -> grants 0,1,0,1,0,1 and rsp_valid pattern 01,10,01,10,01,10 each delayed by one cycle.
- Requester 1 alone valid for 3 cycles, then both valid -> requester 0 granted next (last_grant=1); no cycle without a grant.
- Read accepted in cycle N, reset pulsed in cycle N+1 -> rsp_valid stays 0, last_grant returns to 1, RAM contents written earlier remain readable after reset.
- Write to addr 0x3F then to addr 0x00, then read both back -> stored values returned, no aliasing across the wrap boundary.
